// File: rtl/mux_nx1_seq_if.sv
// Bus bundle for mux_nx1_seq: N parallel channel inputs, control, and the
// registered output with its valid/ready handshake plus a debug state bit.
interface mux_nx1_seq_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_bus;
  logic [SELW-1:0]    sel;
  logic               mode;
  logic               en;
  logic               y_ready;
  logic [WIDTH-1:0]   y;
  logic [SELW-1:0]    ch;
  logic               y_valid;
  logic               err;
  logic               scan_state;

  modport master (
    output in_bus, sel, mode, en, y_ready,
    input  y, ch, y_valid, err, scan_state
  );

  modport slave (
    input  in_bus, sel, mode, en, y_ready,
    output y, ch, y_valid, err, scan_state
  );
endinterface

// File: rtl/mux_nx1_seq.sv
// Registered N:1 mux with manual select or round-robin scan, valid/ready output.
// Scan mode is compiled in only when MUX_NX1_SCAN_EN is defined.
module mux_nx1_seq #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst,
  mux_nx1_seq_if.slave bus
);
  localparam int SELW = $clog2(N);

  typedef enum logic {ST_MANUAL = 1'b0, ST_SCAN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             y_valid_q, y_valid_d;
  logic             err_q, err_d;
  logic             transition, can_load, load_man, load_scan, sel_in_range;
  logic [WIDTH-1:0] chan [N];

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chan[i] = bus.in_bus[i*WIDTH +: WIDTH];
  end

  assign sel_in_range = ({1'b0, bus.sel} < (SELW+1)'(N));

  // Handshake: y/ch are consumed on an edge with y_valid && y_ready; a new
  // sample may load only when the register is empty or being consumed.
  assign can_load = bus.en && (!y_valid_q || bus.y_ready);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_MANUAL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef MUX_NX1_SCAN_EN
    state_d = bus.mode ? ST_SCAN : ST_MANUAL;
`endif
  end

  // A mode-change edge is a pure transition: no capture, no err.
  always_comb begin
    transition = (state_d != state_q);
    load_man   = (state_q == ST_MANUAL) && !transition && can_load && sel_in_range;
    load_scan  = (state_q == ST_SCAN) && !transition && can_load;
    err_d      = (state_q == ST_MANUAL) && !transition && bus.en && !sel_in_range;
  end

`ifdef MUX_NX1_SCAN_EN
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [DCW-1:0]  dcnt_q, dcnt_d;

  always_comb begin
    ptr_d  = ptr_q;
    dcnt_d = dcnt_q;
    if (transition) begin
      ptr_d  = '0;
      dcnt_d = '0;
    end else if (load_scan) begin
      if (dcnt_q == DCW'(DWELL - 1)) begin
        dcnt_d = '0;
        ptr_d  = (ptr_q == SELW'(N - 1)) ? '0 : ptr_q + 1'b1;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      dcnt_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      dcnt_q <= dcnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = bus.mode ^ (DWELL > 0);
`endif

  always_comb begin
    y_d       = y_q;
    ch_d      = ch_q;
    y_valid_d = y_valid_q;
    if (load_man) begin
      y_d       = chan[bus.sel];
      ch_d      = bus.sel;
      y_valid_d = 1'b1;
`ifdef MUX_NX1_SCAN_EN
    end else if (load_scan) begin
      y_d       = chan[ptr_q];
      ch_d      = ptr_q;
      y_valid_d = 1'b1;
`endif
    end else if (bus.y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      ch_q      <= '0;
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      y_q       <= y_d;
      ch_q      <= ch_d;
      y_valid_q <= y_valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.y          = y_q;
  assign bus.ch         = ch_q;
  assign bus.y_valid    = y_valid_q;
  assign bus.err        = err_q;
  assign bus.scan_state = (state_q == ST_SCAN);
endmodule

// File: tb/tb_mux_nx1_seq.sv
// Self-checking bench for mux_nx1_seq: an N=4 and an N=3 instance driven in
// parallel, compared each cycle against a sample-count reference model.
module tb_mux_nx1_seq;
  localparam int W  = 8;
  localparam int DW = 2;

`ifdef MUX_NX1_SCAN_EN
  localparam bit SCAN_BUILD = 1'b1;
`else
  localparam bit SCAN_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] drv_bus;
  logic [1:0]  drv_sel;
  logic        drv_mode, drv_en, drv_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_nx1_seq_if #(.WIDTH(W), .N(4)) if4 ();
  mux_nx1_seq_if #(.WIDTH(W), .N(3)) if3 ();

  assign if4.in_bus  = drv_bus;
  assign if4.sel     = drv_sel;
  assign if4.mode    = drv_mode;
  assign if4.en      = drv_en;
  assign if4.y_ready = drv_ready;
  assign if3.in_bus  = drv_bus[23:0];
  assign if3.sel     = drv_sel;
  assign if3.mode    = drv_mode;
  assign if3.en      = drv_en;
  assign if3.y_ready = drv_ready;

  mux_nx1_seq #(.WIDTH(W), .N(4), .DWELL(DW)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  mux_nx1_seq #(.WIDTH(W), .N(3), .DWELL(DW)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  // Reference model: in scan mode the channel is derived from the number of
  // samples accepted since scan was entered, (k / DWELL) mod N.
  int         m_n [2] = '{4, 3};
  bit         m_scan [2];
  int         m_k [2];
  logic [7:0] m_y [2];
  int         m_ch [2];
  bit         m_valid [2];
  bit         m_err [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan_val(input int c);
    logic [31:0] b;
    b = drv_bus >> (c * 8);
    return b[7:0];
  endfunction

  task automatic model_step(input int i);
    bit trans, can, load;
    int c;
    if (rst) begin
      m_scan[i] = 0; m_k[i] = 0; m_y[i] = 8'h00; m_ch[i] = 0;
      m_valid[i] = 0; m_err[i] = 0;
      return;
    end
    trans = SCAN_BUILD && (drv_mode != m_scan[i]);
    can   = drv_en && (!m_valid[i] || drv_ready);
    load  = 0;
    c     = 0;
    m_err[i] = 0;
    if (trans) begin
      m_scan[i] = drv_mode;
      m_k[i]    = 0;
    end else if (!m_scan[i]) begin
      if (drv_en && int'(drv_sel) >= m_n[i]) m_err[i] = 1;
      else if (can) begin load = 1; c = int'(drv_sel); end
    end else if (can) begin
      load = 1;
      c = (m_k[i] / DW) % m_n[i];
      m_k[i]++;
    end
    if (load) begin
      m_y[i] = chan_val(c); m_ch[i] = c; m_valid[i] = 1;
    end else if (drv_ready) begin
      m_valid[i] = 0;
    end
  endtask

  task automatic check_inst(input int i);
    if (i == 0) begin
      check_eq("y4", 32'(if4.y), 32'(m_y[0]));
      check_eq("ch4", 32'(if4.ch), 32'(m_ch[0]));
      check_eq("valid4", 32'(if4.y_valid), 32'(m_valid[0]));
      check_eq("err4", 32'(if4.err), 32'(m_err[0]));
      check_eq("state4", 32'(if4.scan_state), 32'(m_scan[0]));
    end else begin
      check_eq("y3", 32'(if3.y), 32'(m_y[1]));
      check_eq("ch3", 32'(if3.ch), 32'(m_ch[1]));
      check_eq("valid3", 32'(if3.y_valid), 32'(m_valid[1]));
      check_eq("err3", 32'(if3.err), 32'(m_err[1]));
      check_eq("state3", 32'(if3.scan_state), 32'(m_scan[1]));
    end
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  initial begin
    logic [7:0] man_exp [4];
    man_exp = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1; drv_bus = 32'h44332211; drv_sel = 2'd0;
    drv_mode = 1'b0; drv_en = 1'b0; drv_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_y", 32'(if4.y), 32'h0);
    check_eq("rst_valid", 32'(if4.y_valid), 32'h0);

    // Manual stepping; sel=3 is out of range on the N=3 instance.
    drv_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv_sel = 2'(i);
      step();
      check_eq("man_y", 32'(if4.y), 32'(man_exp[i]));
      check_eq("man_ch", 32'(if4.ch), 32'(i));
      check_eq("man_valid", 32'(if4.y_valid), 32'h1);
    end
    check_eq("oor_err", 32'(if3.err), 32'h1);
    check_eq("oor_valid", 32'(if3.y_valid), 32'h0);
    check_eq("oor_y_hold", 32'(if3.y), 32'h33);
    drv_sel = 2'd0;
    step();
    check_eq("oor_err_once", 32'(if3.err), 32'h0);

    // Scan round, then a 3-cycle stall, then resume.
    drv_mode = 1'b1;
    for (int i = 0; i < 4; i++) step();
    drv_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    drv_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Reset mid-scan, then re-enter scan.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_y", 32'(if4.y), 32'h0);
    check_eq("midrst_ch", 32'(if4.ch), 32'h0);
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic including mode flips mid-stall and sporadic reset.
    for (int i = 0; i < 800; i++) begin
      drv_bus   = $urandom;
      drv_sel   = 2'($urandom_range(0, 3));
      drv_en    = ($urandom_range(0, 3) != 0);
      drv_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) drv_mode = ~drv_mode;
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
